// File: rtl/spill_count_buffer_pkg.sv
// -----------------------------------------------------------------------------
// spill_count_buffer_pkg
//   Shared defaults and types for the spill count buffer slice.
//   DEPTH_DEF / CNT_W_DEF / ID_W_DEF : default FIFO depth, count width, id width
//   entry_t     : one FIFO record {spill_id, count} at the default widths
//   arm_state_t : spill gate tracking state
//   sat_inc8    : saturating 8-bit increment used by the drop counter
// -----------------------------------------------------------------------------
package spill_count_buffer_pkg;

   localparam int unsigned DEPTH_DEF = 8;
   localparam int unsigned CNT_W_DEF = 32;
   localparam int unsigned ID_W_DEF  = 16;

   typedef struct packed {
      logic [ID_W_DEF-1:0]  spill_id;
      logic [CNT_W_DEF-1:0] count;
   } entry_t;

   // ARM_BLOCKED: out of reset, waiting to see the gate low before trusting edges
   // ARM_IDLE   : gate low or spill not armed
   // ARM_SET    : rising edge seen, next falling edge captures
   typedef enum logic [1:0] {
      ARM_BLOCKED = 2'd0,
      ARM_IDLE    = 2'd1,
      ARM_SET     = 2'd2
   } arm_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/spill_count_buffer_if.sv
// -----------------------------------------------------------------------------
// spill_count_buffer_if
//   Read-side valid/ready handshake of the spill count buffer.
//   rd_valid : head entry available (driven by master)
//   rd_ready : consumer accepts head (driven by slave)
//   rd_data  : {spill_id, count} of the head entry (driven by master)
// -----------------------------------------------------------------------------
interface spill_count_buffer_if
   import spill_count_buffer_pkg::*;
#(
   parameter int unsigned ID_W  = ID_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) ();

   logic                    rd_valid;
   logic                    rd_ready;
   logic [ID_W+CNT_W-1:0]   rd_data;

   modport master (output rd_valid, output rd_data, input  rd_ready);
   modport slave  (input  rd_valid, input  rd_data, output rd_ready);

endinterface

// File: rtl/spill_count_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock 1-write/1-read register-array FIFO.
//   clk, rst (async, active-low), clear (sync flush)
//   wr_en/wr_data : write request; accepted when not full, or when full and a
//                   read happens in the same cycle
//   rd_en         : read request; ignored while empty
//   rd_data       : raw head slot (meaningful only while !empty)
//   full, empty, occupancy : status
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned OCC_W = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign empty = (occupancy == '0);
   assign full  = (occupancy == OCC_W'(DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // DEPTH is a power of two, so pointer wrap is plain binary overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd)      occupancy <= occupancy + 1'b1;
         else if (do_rd && !do_wr) occupancy <= occupancy - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !clear) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/spill_count_buffer.sv
// -----------------------------------------------------------------------------
// spill_count_buffer
//   Captures the upstream trigger count at the end of each spill, tags it with
//   a spill sequence number and queues it for a valid/ready consumer.
//   clk, rst (async, active-low)
//   live       : spill gate
//   input_rate : running trigger count, sampled on the gate's falling edge
//   clear      : sync flush of FIFO and statistics (spill id kept)
//   rd         : master side of the read handshake {rd_valid, rd_ready, rd_data}
//   occupancy  : entries stored
//   overflow   : sticky, a capture was dropped on a full FIFO
//   drop_count : dropped captures, saturating at 255
//   peak_count : largest captured count since reset/clear
// -----------------------------------------------------------------------------
module spill_count_buffer
   import spill_count_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned ID_W  = ID_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     live,
   input  logic [CNT_W-1:0]         input_rate,
   input  logic                     clear,
   spill_count_buffer_if.master     rd,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow,
   output logic [7:0]               drop_count,
   output logic [CNT_W-1:0]         peak_count
);

   localparam int unsigned EW = ID_W + CNT_W;

   logic             live_d;
   logic             rise;
   logic             fall;
   logic             capture;
   logic             pop;
   logic             store;
   logic             drop;
   logic             full;
   logic             empty;
   logic [ID_W-1:0]  spill_id;
   logic [EW-1:0]    head;
   arm_state_t       state_q;
   arm_state_t       state_d;

   assign rise = live & ~live_d;
   assign fall = ~live & live_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) live_d <= 1'b0;
      else      live_d <= live;
   end

   // Arm tracking. live_d resets to 0, so a gate already high at reset release
   // would look like a rising edge; ARM_BLOCKED waits for the gate to be seen
   // low first, which discards spills in progress across reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ARM_BLOCKED;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARM_BLOCKED: if (!live) state_d = ARM_IDLE;
         ARM_IDLE:    if (rise)  state_d = ARM_SET;
         ARM_SET:     if (fall)  state_d = ARM_IDLE;
         default:                state_d = ARM_BLOCKED;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      if (state_q == ARM_SET && fall) capture = 1'b1;
   end

   // Clear wins over both pop and store; a pop on a full FIFO frees the slot
   // for a same-cycle capture.
   assign pop   = ~empty & rd.rd_ready & ~clear;
   assign store = capture & ~clear & (~full | pop);
   assign drop  = capture & ~clear & full & ~pop;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .wr_en     (store),
      .wr_data   ({spill_id, input_rate}),
      .rd_en     (pop),
      .rd_data   (head),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy)
   );

   assign rd.rd_valid = ~empty;
   assign rd.rd_data  = empty ? '0 : head;

   // Every capture consumes an id, including dropped and cleared ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         spill_id <= '0;
      else if (capture) spill_id <= spill_id + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
         peak_count <= '0;
      end else if (clear) begin
         overflow   <= 1'b0;
         drop_count <= '0;
         peak_count <= '0;
      end else begin
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc8(drop_count);
         end
         if (capture && input_rate > peak_count) peak_count <= input_rate;
      end
   end

endmodule
